// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-outstanding memory port between an instruction-fetch
// requester (i_*) and a data requester (d_*). Data normally wins. A starvation
// counter forces a fetch win after STARVE_MAX consecutive data wins taken while
// fetch was waiting.
//
// Transaction flow: IDLE (arbitrate, latch winner) -> REQ (hold m_req until
// m_gnt) -> RESP (wait for m_rvalid) -> IDLE. The shortest transaction is
// three cycles.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_req/i_addr                    fetch request and address
//   i_gnt/i_rvalid/i_rdata          fetch accept pulse, data-valid pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be  data request (load or store)
//   d_gnt/d_rvalid/d_rdata          data accept pulse, load-data/store-ack, data
//   m_req/m_we/m_addr/m_wdata/m_be  latched request to the shared memory
//   m_gnt/m_rvalid/m_rdata          memory accept, response valid, read data
//   busy                            high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,

  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               m_we_q, m_we_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]    m_be_q, m_be_d;
  logic               fetch_win;

  // NOTE: every flop uses <= so all registers update from the same pre-edge
  // values; blocking assignments here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DATA;
      starve_cnt_q <= '0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;

    // Fetch only beats a pending data request once it has been starved.
    fetch_win = i_req && (!d_req || (starve_cnt_q == STARVE_LIM));

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = REQ;
          if (fetch_win) begin
            owner_d      = OWN_FETCH;
            m_we_d       = 1'b0;
            m_addr_d     = i_addr;
            m_be_d       = '1;
            starve_cnt_d = '0;
          end else begin
            owner_d   = OWN_DATA;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
            // Only a data win that actually made fetch wait counts as starvation.
            if (i_req) begin
              starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM
                                                          : starve_cnt_q + CNT_W'(1);
            end else begin
              starve_cnt_d = '0;
            end
          end
        end
      end

      REQ: begin
        // Grant is passed straight through so the requester sees it in the
        // same cycle the memory accepts.
        if (m_gnt) begin
          i_gnt   = (owner_q == OWN_FETCH);
          d_gnt   = (owner_q == OWN_DATA);
          state_d = RESP;
        end
      end

      RESP: begin
        if (m_rvalid) begin
          i_rvalid = (owner_q == OWN_FETCH);
          d_rvalid = (owner_q == OWN_DATA);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign m_req   = (state_q == REQ);
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  assign busy    = (state_q != IDLE);

  // Read data is not registered; only the owner's rvalid qualifies it.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule
